// File: rtl/pmc_pkg.sv
// -----------------------------------------------------------------------------
// pmc_pkg
//   Shared definitions for the pipelined magnitude comparator.
//   - cmp_res_e : one-hot compare result (GT=3'b100, EQ=3'b010, LT=3'b001),
//                 RES_NONE marks an empty pipeline slot.
//   - cmp_result: compares two operands of up to PMC_MAX_W bits, either as
//                 unsigned magnitudes or as two's-complement values whose sign
//                 bit sits at index msb.
// -----------------------------------------------------------------------------
package pmc_pkg;

  // Operands are zero-extended to this width before being handed to
  // cmp_result, so any WIDTH up to PMC_MAX_W is supported.
  localparam int PMC_MAX_W = 64;
  localparam int PMC_IDX_W = $clog2(PMC_MAX_W);

  typedef enum logic [2:0] {
    RES_NONE = 3'b000,
    RES_GT   = 3'b100,
    RES_EQ   = 3'b010,
    RES_LT   = 3'b001
  } cmp_res_e;

  // Two's-complement ordering equals unsigned ordering once the sign bit of
  // both operands is inverted: negatives move below all non-negatives while
  // the relative order within each half is preserved.
  function automatic cmp_res_e cmp_result(
    input logic [PMC_MAX_W-1:0] a,
    input logic [PMC_MAX_W-1:0] b,
    input logic                 signed_mode,
    input logic [PMC_IDX_W-1:0] msb
  );
    logic [PMC_MAX_W-1:0] ax;
    logic [PMC_MAX_W-1:0] bx;
    cmp_res_e             res;
    ax = a;
    bx = b;
    if (signed_mode) begin
      ax[msb] = ~ax[msb];
      bx[msb] = ~bx[msb];
    end
    if (ax > bx) begin
      res = RES_GT;
    end else if (ax == bx) begin
      res = RES_EQ;
    end else begin
      res = RES_LT;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipelined_magnitude_comparator_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that stops at MAX instead of wrapping. clr has priority over
//   inc; rst is synchronous and active high.
//
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous active-high reset (count -> 0)
//     clr   in   synchronous clear (count -> 0), wins over inc
//     inc   in   increment request, ignored once count == MAX
//     count out  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipelined_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// pipelined_magnitude_comparator
//   Two-stage registered comparator for WIDTH-bit operands, unsigned or
//   two's-complement per transaction, with saturating per-outcome counters
//   and an equal-streak detector.
//
//   Handshake (both sides): a transfer happens on a rising edge where
//   valid && ready. A producer holds valid and data stable until the transfer;
//   ready may depend combinationally on the consumer's ready (in_ready follows
//   out_ready through the advance chain) but never on in_valid.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   operand handshake
//     A, B, signed_mode   operands and compare mode, captured together
//     clear               synchronous clear of counters and streak
//     out_valid/out_ready result handshake
//     A_greater/A_equal/A_less  one-hot result, all 0 while out_valid=0
//     gt_count/eq_count/lt_count saturating counts of accepted results
//     eq_streak           last STREAK accepted results were all equal
//
//   Parameters: WIDTH >= 2 (and <= 64), CNT_W >= 1, 1 <= STREAK < 2**CNT_W.
// -----------------------------------------------------------------------------
module pipelined_magnitude_comparator
  import pmc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int STREAK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A_greater,
  output logic             A_equal,
  output logic             A_less,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic             eq_streak
);

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;

  // Stage 2: compare result
  logic             s2_valid_q, s2_valid_d;
  logic [2:0]       res_q, res_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             out_hs;
  logic [CNT_W-1:0] streak_cnt;

  // A stage may take new content when it is empty or its content moves on
  // in the same cycle; the chain gives full-throughput bubble-free flow.
  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign out_hs = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    sm_d       = sm_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d  = A;
        b_d  = B;
        sm_d = signed_mode;
      end
    end

    // An empty slot carries RES_NONE so the flags read 0 with out_valid=0
    // straight from the register, with no output gating.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d = cmp_result(PMC_MAX_W'(a_q), PMC_MAX_W'(b_q), sm_q,
                           PMC_IDX_W'(WIDTH - 1));
      end else begin
        res_d = RES_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sm_q       <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= RES_NONE;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sm_q       <= sm_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign A_greater = res_q[2];
  assign A_equal   = res_q[1];
  assign A_less    = res_q[0];

  // Event counters: count only results actually taken downstream.
  sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_gt_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (out_hs && res_q[2]),
    .count(gt_count)
  );

  sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_eq_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (out_hs && res_q[1]),
    .count(eq_count)
  );

  sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_lt_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (out_hs && res_q[0]),
    .count(lt_count)
  );

  // Streak: a non-equal accepted result restarts the run; parking the count
  // at STREAK keeps eq_streak high for as long as equal results continue.
  sat_counter #(.W(CNT_W), .MAX(CNT_W'(STREAK))) u_streak_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear || (out_hs && !res_q[1])),
    .inc  (out_hs && res_q[1]),
    .count(streak_cnt)
  );

  // streak_cnt is a register, so this decode adds no combinational path
  // from the inputs.
  assign eq_streak = (streak_cnt == CNT_W'(STREAK));

endmodule
